// File: rtl/locked_reg_pkg.sv
// +----------------------------------------------------------------------+
// | locked_reg_pkg: shared state encoding and defaults for locked-register |
// | access ports.                           Revision: 1.0                 |
// +----------------------------------------------------------------------+
`default_nettype none

package locked_reg_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_REG_COUNT  = 4;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_IRQ_THRESH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } rd_state_t;

  // A single-register port still needs a one-bit address bus.
  function automatic int addr_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lock_access_check.sv
// +----------------------------------------------------------------------+
// | lock_access_check: combinational grant/deny policy for one register  |
// | access; shared by the read and write sides.   Revision: 1.0          |
// +----------------------------------------------------------------------+
`default_nettype none

module lock_access_check
  import locked_reg_pkg::*;
#(
  parameter int REG_COUNT = DEF_REG_COUNT,
  localparam int ADDR_W   = addr_width(REG_COUNT)
) (
  input  logic [ADDR_W-1:0]    addr,
  input  logic [REG_COUNT-1:0] lock_status,
  input  logic                 scan_mode,
  input  logic                 debug_unlocked,
  output logic                 deny
);

  localparam int PAD_W = 1 << ADDR_W;

  logic [PAD_W-1:0] lock_pad;
  logic             out_of_range;
  logic             locked;

  // Lock bits are padded to the full address space so that an out-of-range
  // index never selects a nonexistent bit; range is denied separately.
  always_comb begin
    lock_pad                  = '0;
    lock_pad[REG_COUNT-1:0]   = lock_status;
    out_of_range              = ({1'b0, addr} >= (ADDR_W + 1)'(REG_COUNT));
    locked                    = lock_pad[addr];
    deny                      = scan_mode | out_of_range | (locked & ~debug_unlocked);
  end

endmodule

`default_nettype wire

// File: rtl/locked_reg_read_port.sv
// +----------------------------------------------------------------------+
// | locked_reg_read_port: three-phase read port with lock enforcement,   |
// | saturating violation counter and sticky irq.   Revision: 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module locked_reg_read_port
  import locked_reg_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_COUNT  = DEF_REG_COUNT,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int IRQ_THRESH = DEF_IRQ_THRESH,
  localparam int ADDR_W    = addr_width(REG_COUNT)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [REG_COUNT*DATA_W-1:0] Reg_data,
  input  logic [REG_COUNT-1:0]        Lock_status,
  input  logic                        scan_mode,
  input  logic                        debug_unlocked,
  input  logic                        Rd_req,
  input  logic [ADDR_W-1:0]           Rd_addr,
  input  logic                        Rd_ack,
  output logic                        Rd_busy,
  output logic                        Rd_valid,
  output logic [DATA_W-1:0]           Rd_data,
  output logic                        Rd_err,
  output logic [CNT_W-1:0]            Violation_count,
  output logic                        Violation_irq,
  input  logic                        Irq_clear
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rd_state_t         state;
  rd_state_t         next_state;
  logic [ADDR_W-1:0] addr_lat;
  logic [DATA_W-1:0] word_sel;
  logic              deny;
  logic              denial;
  logic [CNT_W-1:0]  cnt_base;
  logic [CNT_W-1:0]  cnt_next;
  logic              irq_next;

  lock_access_check #(
    .REG_COUNT (REG_COUNT)
  ) u_access (
    .addr           (addr_lat),
    .lock_status    (Lock_status),
    .scan_mode      (scan_mode),
    .debug_unlocked (debug_unlocked),
    .deny           (deny)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (Rd_req) next_state = ST_CHECK;
      ST_CHECK: next_state = ST_RESP;
      ST_RESP:  if (Rd_ack) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  assign Rd_busy = (state != ST_IDLE);
  assign denial  = (state == ST_CHECK) & deny;

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (addr_lat == ADDR_W'(i)) word_sel = Reg_data[i*DATA_W +: DATA_W];
    end
  end

  // Clear acts first, so a coincident denial lands on a zeroed counter.
  always_comb begin
    cnt_base = Irq_clear ? '0 : Violation_count;
    cnt_next = cnt_base;
    if (denial && (cnt_base != CNT_MAX)) cnt_next = cnt_base + 1'b1;
    irq_next = (Violation_irq & ~Irq_clear) | (32'(cnt_next) >= 32'(IRQ_THRESH));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_lat        <= '0;
      Rd_valid        <= 1'b0;
      Rd_data         <= '0;
      Rd_err          <= 1'b0;
      Violation_count <= '0;
      Violation_irq   <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && Rd_req) addr_lat <= Rd_addr;
      if (state == ST_CHECK) begin
        Rd_valid <= 1'b1;
        Rd_data  <= deny ? '0 : word_sel;
        Rd_err   <= deny;
      end else if ((state == ST_RESP) && Rd_ack) begin
        Rd_valid <= 1'b0;
        Rd_data  <= '0;
        Rd_err   <= 1'b0;
      end
      Violation_count <= cnt_next;
      Violation_irq   <= irq_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_locked_reg_read_port.sv
// Bench for locked_reg_read_port: a default instance and a 3-register,
// 2-bit-counter instance driven in parallel and checked against a model.
`default_nettype none

module tb_locked_reg_read_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] reg_data;
  logic [3:0]  lock;
  logic        scan, dbg, req, ack, clr;
  logic [1:0]  addr;

  logic        busy0, valid0, err0, irq0;
  logic [15:0] data0;
  logic [7:0]  cnt0;
  logic        busy1, valid1, err1, irq1;
  logic [15:0] data1;
  logic [1:0]  cnt1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  locked_reg_read_port dut0 (
    .Clk(clk), .Reset(rst), .Reg_data(reg_data), .Lock_status(lock),
    .scan_mode(scan), .debug_unlocked(dbg), .Rd_req(req), .Rd_addr(addr),
    .Rd_ack(ack), .Rd_busy(busy0), .Rd_valid(valid0), .Rd_data(data0),
    .Rd_err(err0), .Violation_count(cnt0), .Violation_irq(irq0), .Irq_clear(clr)
  );

  locked_reg_read_port #(.DATA_W(16), .REG_COUNT(3), .CNT_W(2), .IRQ_THRESH(3)) dut1 (
    .Clk(clk), .Reset(rst), .Reg_data(reg_data[47:0]), .Lock_status(lock[2:0]),
    .scan_mode(scan), .debug_unlocked(dbg), .Rd_req(req), .Rd_addr(addr),
    .Rd_ack(ack), .Rd_busy(busy1), .Rd_valid(valid1), .Rd_data(data1),
    .Rd_err(err1), .Violation_count(cnt1), .Violation_irq(irq1), .Irq_clear(clr)
  );

  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Transaction-level reference: phase 0 waiting, 1 deciding, 2 holding.
  int          ph[2], ma[2], mc[2];
  logic        mv[2], me[2], mi[2];
  logic [15:0] md[2];
  bit          model_ok = 0;
  bit          den;
  int          c;
  int          NREG[2] = '{4, 3};
  int          CMAX[2] = '{255, 3};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ph[k] = 0; ma[k] = 0; mc[k] = 0;
        mv[k] = 0; me[k] = 0; mi[k] = 0; md[k] = 0;
      end else begin
        den = 0;
        if (ph[k] == 0) begin
          if (req) begin ma[k] = int'(addr); ph[k] = 1; end
        end else if (ph[k] == 1) begin
          den   = scan || (ma[k] >= NREG[k]) || (lock[ma[k]] && !dbg);
          mv[k] = 1;
          me[k] = den;
          md[k] = den ? 16'h0 : reg_data[ma[k]*16 +: 16];
          ph[k] = 2;
        end else if (ack) begin
          mv[k] = 0; me[k] = 0; md[k] = 0; ph[k] = 0;
        end
        c = clr ? 0 : mc[k];
        if (den && c < CMAX[k]) c = c + 1;
        mi[k] = (clr ? 1'b0 : mi[k]) | (c >= 3);
        mc[k] = c;
      end
    end
    if (rst) model_ok = 1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("busy",  0, busy0,  ph[0] != 0); chk("busy",  1, busy1,  ph[1] != 0);
      chk("valid", 0, valid0, mv[0]);      chk("valid", 1, valid1, mv[1]);
      chk("data",  0, data0,  md[0]);      chk("data",  1, data1,  md[1]);
      chk("err",   0, err0,   me[0]);      chk("err",   1, err1,   me[1]);
      chk("count", 0, cnt0,   mc[0]);      chk("count", 1, cnt1,   mc[1]);
      chk("irq",   0, irq0,   mi[0]);      chk("irq",   1, irq1,   mi[1]);
    end
  end

  // Leaves the port in RESP, one time unit after the response edge.
  task automatic start_rd(input logic [1:0] a, input logic clr_in_check);
    @(posedge clk); #1 req = 1'b1; addr = a;
    @(posedge clk); #1 req = 1'b0; clr = clr_in_check;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic end_rd();
    ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; reg_data = '0; lock = '0; scan = 0; dbg = 0;
    req = 0; ack = 0; clr = 0; addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", 0, busy0, 0);  chk("rst_valid", 0, valid0, 0);
    chk("rst_data", 0, data0, 0);  chk("rst_count", 0, cnt0, 0);

    // Unlocked read of word 2.
    reg_data = {16'hBEEF, 16'hA5A5, 16'h1234, 16'h0F0F};
    start_rd(2'd2, 1'b0);
    chk("lat_valid", 0, valid0, 1); chk("unl_data", 0, data0, 16'hA5A5);
    chk("unl_err", 0, err0, 0);     chk("unl_count", 0, cnt0, 0);
    end_rd();

    // Locked deny, then debug override.
    lock = 4'b0010;
    start_rd(2'd1, 1'b0);
    chk("lck_data", 0, data0, 0); chk("lck_err", 0, err0, 1); chk("lck_count", 0, cnt0, 1);
    end_rd();
    dbg = 1'b1;
    start_rd(2'd1, 1'b0);
    chk("dbg_data", 0, data0, 16'h1234); chk("dbg_err", 0, err0, 0); chk("dbg_count", 0, cnt0, 1);
    end_rd();

    // Scan overrides debug on an unlocked register.
    scan = 1'b1; lock = 4'b0000;
    start_rd(2'd0, 1'b0);
    chk("scan_data", 0, data0, 0); chk("scan_err", 0, err0, 1); chk("pre_irq", 0, irq0, 0);
    end_rd();

    // Third denial raises irq.
    scan = 1'b0; dbg = 1'b0; lock = 4'b0010;
    start_rd(2'd1, 1'b0);
    chk("irq3", 0, irq0, 1); chk("cnt3", 0, cnt0, 3); chk("irq3", 1, irq1, 1);
    end_rd();

    // Two more denials: narrow counter saturates.
    for (int i = 0; i < 2; i++) begin start_rd(2'd1, 1'b0); end_rd(); end
    chk("cnt5", 0, cnt0, 5); chk("sat", 1, cnt1, 3);

    // Clear coincident with a denial.
    start_rd(2'd1, 1'b1);
    chk("clr_cnt", 0, cnt0, 1); chk("clr_cnt", 1, cnt1, 1); chk("clr_irq", 0, irq0, 0);
    end_rd();

    // Out of range only on the three-register instance.
    lock = 4'b0000;
    start_rd(2'd3, 1'b0);
    chk("oor_data", 0, data0, 16'hBEEF); chk("oor_data", 1, data1, 0); chk("oor_err", 1, err1, 1);
    end_rd();

    // Backpressure: held response ignores lock/scan/request churn.
    start_rd(2'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1
      lock = 4'($urandom); scan = 1'($urandom); req = ~req; addr = 2'($urandom);
      chk("bp_valid", 0, valid0, 1); chk("bp_data", 0, data0, 16'hA5A5); chk("bp_err", 0, err0, 0);
    end
    req = 1'b0; scan = 1'b0; lock = 4'b0000;
    end_rd();
    chk("bp_idle", 0, busy0, 0); chk("bp_vclr", 0, valid0, 0);

    // Reset while a response is held.
    start_rd(2'd2, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rr_busy", 0, busy0, 0); chk("rr_valid", 0, valid0, 0); chk("rr_data", 0, data0, 0);
    chk("rr_cnt", 0, cnt0, 0);
    start_rd(2'd2, 1'b0);
    chk("rr_again", 0, data0, 16'hA5A5);
    end_rd();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1
      rst  = ($urandom_range(0, 199) == 0);
      req  = 1'($urandom);
      addr = 2'($urandom);
      ack  = ($urandom_range(0, 2) != 0);
      lock = 4'($urandom);
      scan = ($urandom_range(0, 7) == 0);
      dbg  = 1'($urandom);
      clr  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) reg_data = {$urandom, $urandom};
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/locked_reg_read_port.md
LOCKED_REG_READ_PORT -- requirements
Module: locked_reg_read_port

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of each register word.
REQ-002 SHALL have parameter REG_COUNT, default 4, number of registers served; address width ADDR_W = clog2(REG_COUNT).
REQ-003 SHALL have parameter CNT_W, default 8, width of the violation counter.
REQ-004 SHALL have parameter IRQ_THRESH, default 3, violation count at which Violation_irq sets.
REQ-005 SHALL provide ports as follows; one clock; reset is synchronous and active-high:
- Clk  in  1  sole clock; all state updates on its rising edge.
- Reset  in  1  synchronous active-high reset.
- Reg_data  in  REG_COUNT*DATA_W  flattened register contents; word i at bits [i*DATA_W +: DATA_W].
- Lock_status  in  REG_COUNT  per-register lock bit; 1 = locked.
- scan_mode  in  1  scan active; all reads are blocked.
- debug_unlocked  in  1  debug override; permits reads of locked registers when scan_mode=0.
- Rd_req  in  1  read request; qualified only in IDLE.
- Rd_addr  in  ADDR_W  register index; sampled with Rd_req.
- Rd_ack  in  1  requester accepts the response.
- Rd_busy  out  1  high in every state other than IDLE.
- Rd_valid  out  1  response valid.
- Rd_data  out  DATA_W  response data.
- Rd_err  out  1  access denied or address out of range.
- Violation_count  out  CNT_W  saturating count of denied reads.
- Violation_irq  out  1  sticky interrupt flag.
- Irq_clear  in  1  clears Violation_irq and Violation_count.

Function
REQ-006 SHALL implement FSM IDLE -> CHECK -> RESP -> IDLE.
REQ-007 IDLE: when Rd_req=1, SHALL latch Rd_addr and move to CHECK; when Rd_req=0, SHALL stay in IDLE.
REQ-008 CHECK SHALL last exactly one cycle and SHALL evaluate access using Lock_status, scan_mode and debug_unlocked sampled in that cycle.
REQ-009 Access is denied when any of the following holds: scan_mode=1; latched address >= REG_COUNT; Lock_status[addr]=1 and debug_unlocked=0.
REQ-010 On grant, SHALL register Rd_data = the word at the latched address in that cycle, with Rd_err=0.
REQ-011 On deny, SHALL register Rd_data = 0 and Rd_err=1; SHALL never expose register contents on a denied read.
REQ-012 RESP SHALL hold Rd_valid=1 with Rd_data and Rd_err stable until Rd_ack=1, then return to IDLE.
REQ-013 A cycle with Rd_ack=1 in RESP SHALL clear Rd_valid on the next edge; the earliest next request is accepted in the cycle after that.
REQ-014 Latency: Rd_req at edge N SHALL give Rd_valid=1 after edge N+2.
REQ-015 Rd_data SHALL be 0 whenever Rd_valid=0.
REQ-016 Each denied read SHALL increment Violation_count by 1 on the CHECK edge; the count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-017 Violation_irq SHALL set when the counter's next value >= IRQ_THRESH and SHALL stay set until Irq_clear or Reset.
REQ-018 Irq_clear=1 SHALL zero the count and the irq. If a denial occurs in the same cycle, the result SHALL be count=1, with the irq evaluated against 1.
REQ-019 Rd_req and Rd_addr changes outside IDLE SHALL be ignored.
REQ-020 Lock or scan_mode changes after CHECK SHALL NOT alter a response already held in RESP.

Reset
REQ-021 Reset=1 at a rising edge SHALL force: state IDLE, Rd_busy=0, Rd_valid=0, Rd_data=0, Rd_err=0, Violation_count=0, Violation_irq=0, latched address 0.
REQ-022 Reset SHALL take priority over all inputs, including mid-transaction in CHECK or RESP; a pending response SHALL be discarded without an Rd_ack.

Structure
REQ-023 The FSM state enum and the default DATA_W/REG_COUNT/CNT_W constants SHALL live in shared package locked_reg_pkg.
REQ-024 Access policy (REQ-009) SHALL be a combinational sub-module named lock_access_check, reusable by the write side.

Verification
REQ-025 Unlocked read: Reg_data word2=16'hA5A5, Lock_status=4'b0000, read addr 2 -> Rd_valid after 2 edges, Rd_data=16'hA5A5, Rd_err=0, count unchanged.
REQ-026 Locked deny then debug: Lock_status[1]=1, word1=16'h1234 -> read returns Rd_data=0, Rd_err=1, count=1; repeat with debug_unlocked=1 -> Rd_data=16'h1234, Rd_err=0, count=1.
REQ-027 Scan blocks debug: scan_mode=1, debug_unlocked=1, unlocked addr 0 -> Rd_data=0, Rd_err=1.
REQ-028 Irq and saturation: 3 denied reads -> Violation_irq=1 at the third CHECK; with CNT_W=2, 5 denials -> count stays 3; Irq_clear coincident with a denial -> count=1.
REQ-029 Backpressure: hold Rd_ack=0 for 10 cycles while toggling Lock_status and Rd_req -> Rd_valid, Rd_data and Rd_err stay stable; Rd_ack=1 -> IDLE on the next edge.
REQ-030 Reset in RESP: Reset=1 for one cycle while Rd_valid=1 -> next cycle all outputs 0, state IDLE, a fresh request completes normally.
